// File: rtl/gate_sweep_unit.sv
// Self-sequencing sweep of every N-bit vector through a selectable N-input reduction gate.
// Optional pause input is compiled in when GATE_SWEEP_PAUSE_EN is defined.
module gate_sweep_unit #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic [2:0]   mode,
`ifdef GATE_SWEEP_PAUSE_EN
  input  logic         pause,
`endif
  output logic [N-1:0] a_out,
  output logic         y_out,
  output logic         out_valid,
  output logic [N:0]   ones_count,
  output logic         busy,
  output logic         done
);

  localparam int CW = N + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [N:0]    vec_q;
  logic [2:0]    mode_q;
  logic          gateY;
  logic          stall;
  logic [N-1:0]  vecLow;

`ifdef GATE_SWEEP_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign vecLow = vec_q[N-1:0];

  always_comb begin
    gateY = 1'b0;
    case (mode_q)
      3'd0:    gateY = &vecLow;
      3'd1:    gateY = |vecLow;
      3'd2:    gateY = ^vecLow;
      3'd3:    gateY = ~(&vecLow);
      3'd4:    gateY = ~(|vecLow);
      3'd5:    gateY = ~(^vecLow);
      default: gateY = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // vec_q carries one extra bit so the cycle after the last vector is
  // distinguishable; that cycle is the one that enters DONE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (!stall && vec_q[N]) state_d = DONE;
      DONE:    if (start) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vec_q      <= '0;
      mode_q     <= '0;
      a_out      <= '0;
      y_out      <= 1'b0;
      out_valid  <= 1'b0;
      ones_count <= '0;
    end else begin
      case (state_q)
        RUN: begin
          if (stall || vec_q[N]) begin
            out_valid <= 1'b0;
          end else begin
            a_out      <= vecLow;
            y_out      <= gateY;
            out_valid  <= 1'b1;
            ones_count <= ones_count + CW'(gateY);
            vec_q      <= vec_q + CW'(1);
          end
        end
        default: begin
          out_valid <= 1'b0;
          if (start) begin
            mode_q     <= mode;
            vec_q      <= '0;
            ones_count <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gate_sweep_unit.sv
// Directed bench for gate_sweep_unit (N=4 and N=2 instances); exercises pause
// only when GATE_SWEEP_PAUSE_EN is defined.
module tb_gate_sweep_unit;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, start2;
  logic [2:0] mode, mode2;
  logic       pause, pause2;
  logic [3:0] a_out;
  logic       y_out, out_valid, busy, done;
  logic [4:0] ones_count;
  logic [1:0] a2;
  logic       y2, v2, busy2, done2;
  logic [2:0] oc2;
  int         compared = 0;
  int         mismatched = 0;

  always #5 clk = ~clk;

  gate_sweep_unit #(.N(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .mode(mode),
`ifdef GATE_SWEEP_PAUSE_EN
    .pause(pause),
`endif
    .a_out(a_out), .y_out(y_out), .out_valid(out_valid),
    .ones_count(ones_count), .busy(busy), .done(done)
  );

  gate_sweep_unit #(.N(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .start(start2), .mode(mode2),
`ifdef GATE_SWEEP_PAUSE_EN
    .pause(pause2),
`endif
    .a_out(a2), .y_out(y2), .out_valid(v2),
    .ones_count(oc2), .busy(busy2), .done(done2)
  );

  // Reference gate built on a popcount, independent of reduction operators.
  function automatic logic refGate(input int n, input logic [2:0] m, input int v);
    int pop;
    pop = 0;
    for (int b = 0; b < n; b++) pop += (v >> b) & 1;
    case (m)
      3'd0:    return (pop == n);
      3'd1:    return (pop > 0);
      3'd2:    return (pop % 2) == 1;
      3'd3:    return (pop != n);
      3'd4:    return (pop == 0);
      3'd5:    return (pop % 2) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] m);
    start = s;
    mode  = m;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic runSweep(input logic [2:0] m, input int expOnes, input bit disturb, input string tag);
    int run;
    applyStimulus(1'b1, m);
    checkOutput({tag, ":busyE0"}, 32'(busy), 32'd1);
    checkOutput({tag, ":onesE0"}, 32'(ones_count), 32'd0);
    checkOutput({tag, ":validE0"}, 32'(out_valid), 32'd0);
    run = 0;
    for (int i = 0; i < 16; i++) begin
      if (disturb && i == 5) begin start = 1'b1; mode = 3'd7; end
      if (disturb && i == 7) begin start = 1'b0; mode = m; end
      @(posedge clk); #1;
      run += int'(refGate(4, m, i));
      checkOutput($sformatf("%s:valid%0d", tag, i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("%s:a%0d", tag, i), 32'(a_out), 32'(i));
      checkOutput($sformatf("%s:y%0d", tag, i), 32'(y_out), 32'(refGate(4, m, i)));
      checkOutput($sformatf("%s:ones%0d", tag, i), 32'(ones_count), 32'(run));
      checkOutput($sformatf("%s:done%0d", tag, i), 32'(done), 32'd0);
    end
    start = 1'b0;
    @(posedge clk); #1;
    checkOutput({tag, ":doneE17"}, 32'(done), 32'd1);
    checkOutput({tag, ":busyE17"}, 32'(busy), 32'd0);
    checkOutput({tag, ":validE17"}, 32'(out_valid), 32'd0);
    checkOutput({tag, ":onesFinal"}, 32'(ones_count), 32'(expOnes));
    checkOutput({tag, ":aHold"}, 32'(a_out), 32'hF);
  endtask

  initial begin
    int run;
    reset_n = 1'b0;
    start = 1'b0; mode = 3'd0; pause = 1'b0;
    start2 = 1'b0; mode2 = 3'd0; pause2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst:a", 32'(a_out), 32'd0);
    checkOutput("rst:valid", 32'(out_valid), 32'd0);
    checkOutput("rst:ones", 32'(ones_count), 32'd0);
    checkOutput("rst:busy", 32'(busy), 32'd0);
    checkOutput("rst:done", 32'(done), 32'd0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("idle:busy", 32'(busy), 32'd0);

    runSweep(3'd0, 1, 1'b0, "and");
    runSweep(3'd2, 8, 1'b1, "xorDisturb");
    runSweep(3'd3, 15, 1'b0, "nand");
    runSweep(3'd4, 1, 1'b0, "nor");
    runSweep(3'd7, 0, 1'b0, "rsvd");

    // Abort an OR sweep asynchronously right after vector 6 appears.
    applyStimulus(1'b1, 3'd1);
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("abort:a6", 32'(a_out), 32'd6);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abort:a", 32'(a_out), 32'd0);
    checkOutput("abort:y", 32'(y_out), 32'd0);
    checkOutput("abort:valid", 32'(out_valid), 32'd0);
    checkOutput("abort:ones", 32'(ones_count), 32'd0);
    checkOutput("abort:busy", 32'(busy), 32'd0);
    checkOutput("abort:done", 32'(done), 32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    runSweep(3'd1, 15, 1'b0, "orAfterAbort");

`ifdef GATE_SWEEP_PAUSE_EN
    // Hold for three cycles after vector 9; sequence must stay contiguous.
    applyStimulus(1'b1, 3'd2);
    run = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 10) begin
        pause = 1'b1;
        for (int p = 0; p < 3; p++) begin
          @(posedge clk); #1;
          checkOutput($sformatf("pause:valid%0d", p), 32'(out_valid), 32'd0);
          checkOutput($sformatf("pause:aHold%0d", p), 32'(a_out), 32'd9);
          checkOutput($sformatf("pause:busy%0d", p), 32'(busy), 32'd1);
        end
        pause = 1'b0;
      end
      @(posedge clk); #1;
      run += int'(refGate(4, 3'd2, i));
      checkOutput($sformatf("pause:a%0d", i), 32'(a_out), 32'(i));
      checkOutput($sformatf("pause:valid%0d", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("pause:ones%0d", i), 32'(ones_count), 32'(run));
    end
    @(posedge clk); #1;
    checkOutput("pause:done", 32'(done), 32'd1);
    checkOutput("pause:onesFinal", 32'(ones_count), 32'd8);
`endif

    // Narrow build: OR over 2 bits gives 3 ones, done on edge 5.
    start2 = 1'b1; mode2 = 3'd1;
    @(posedge clk); #1;
    start2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("n2:valid%0d", i), 32'(v2), 32'd1);
      checkOutput($sformatf("n2:a%0d", i), 32'(a2), 32'(i));
      checkOutput($sformatf("n2:y%0d", i), 32'(y2), 32'(refGate(2, 3'd1, i)));
      checkOutput($sformatf("n2:done%0d", i), 32'(done2), 32'd0);
    end
    @(posedge clk); #1;
    checkOutput("n2:doneE5", 32'(done2), 32'd1);
    checkOutput("n2:ones", 32'(oc2), 32'd3);
    checkOutput("n2:validE5", 32'(v2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
